// File: rtl/fifo_stream_reader.sv
// Read-side drain controller for the async FIFO: issues credit-limited reads and re-times
// the registered read data through a 3-entry holding buffer onto a valid/ready stream.
// Optional feature: define FIFO_READER_COUNT_EN to add the 16-bit words_delivered counter.
module fifo_stream_reader #(
    parameter int DATA_LENGTH = 32,
    parameter int BUF_DEPTH   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   fifo_empty,
    input  logic [DATA_LENGTH-1:0] fifo_read_data,
    output logic                   fifo_r_en,
    output logic                   m_valid,
    output logic [DATA_LENGTH-1:0] m_data,
    input  logic                   m_ready,
    output logic [1:0]             buf_count
`ifdef FIFO_READER_COUNT_EN
   ,output logic [15:0]            words_delivered
`endif
);

    logic                   inflight;
    logic [1:0]             head;
    logic [1:0]             tail;
    logic [1:0]             occ;
    logic [DATA_LENGTH-1:0] mem [BUF_DEPTH];
    logic                   capture;
    logic                   pop;
    logic [2:0]             credit_used;

    function automatic logic [1:0] wrap_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A read is only issued when the buffer can absorb it even if nothing drains,
    // so m_ready never needs to reach fifo_r_en combinationally.
    assign credit_used = {1'b0, occ} + {2'b00, inflight};
    assign fifo_r_en   = enable & ~fifo_empty & (credit_used < BUF_DEPTH[2:0]);

    assign capture   = inflight;
    assign m_valid   = (occ != 2'd0);
    assign pop       = m_valid & m_ready;
    assign m_data    = mem[head];
    assign buf_count = occ;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= 1'b0;
            head     <= 2'd0;
            tail     <= 2'd0;
            occ      <= 2'd0;
        end else begin
            inflight <= fifo_r_en;
            if (capture) tail <= wrap_inc(tail);
            if (pop)     head <= wrap_inc(head);
            case ({capture, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // NOTE: the holding buffer is reset so m_data reads 0 out of reset instead of
    // exposing stale or unknown contents; with three entries this is cheap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else if (capture) begin
            mem[tail] <= fifo_read_data;
        end
    end

`ifdef FIFO_READER_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   words_delivered <= 16'd0;
        else if (pop) words_delivered <= words_delivered + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: a queue-based FIFO source plus a
// latency/credit model of the delivered stream, compared every cycle, and directed tests.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        fifo_empty;
    logic [31:0] fifo_read_data;
    logic        fifo_r_en;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready;
    logic [1:0]  buf_count;
`ifdef FIFO_READER_COUNT_EN
    logic [15:0] words_delivered;
`endif

    fifo_stream_reader #(.DATA_LENGTH(32), .BUF_DEPTH(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_read_data (fifo_read_data),
        .fifo_r_en      (fifo_r_en),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .buf_count      (buf_count)
`ifdef FIFO_READER_COUNT_EN
       ,.words_delivered(words_delivered)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          rc;
        logic [31:0] data;
    } entry_t;

    logic [31:0] src_q[$];
    entry_t      mq[$];
    logic [31:0] got_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          model_pops = 0;
    int          vis;
    logic        rd_pend = 1'b0;
    logic [31:0] pend_word = '0;
    logic        prev_ren = 1'b0;
    logic        s_ren, s_valid;
    logic [31:0] s_data;
    logic [1:0]  s_bc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected outputs: a word read in cycle N is visible from cycle N+2 until popped;
    // a read may be issued only while fewer than 3 words are read-but-not-popped.
    task automatic compare();
        logic exp_ren;
        vis = 0;
        foreach (mq[i]) if (mq[i].rc <= cyc - 2) vis++;
        exp_ren = enable && !fifo_empty && (mq.size() < 3);
        check("fifo_r_en", {31'd0, fifo_r_en}, {31'd0, exp_ren});
        check("m_valid", {31'd0, m_valid}, {31'd0, vis > 0});
        check("buf_count", {30'd0, buf_count}, vis);
        if (vis > 0) check("m_data", m_data, mq[0].data);
        check("credit", {31'd0, ({30'd0, buf_count} + {31'd0, prev_ren}) <= 32'd3}, 32'd1);
`ifdef FIFO_READER_COUNT_EN
        check("words_delivered", {16'd0, words_delivered}, model_pops & 32'hFFFF);
`endif
    endtask

    task automatic step(input logic en, input logic rdy);
        @(negedge clk);
        if (rd_pend) fifo_read_data = pend_word;
        enable     = en;
        m_ready    = rdy;
        fifo_empty = (src_q.size() == 0);
        #1;
        compare();
        s_ren = fifo_r_en; s_valid = m_valid; s_data = m_data; s_bc = buf_count;
        if (m_valid && m_ready) got_q.push_back(m_data);
        if (vis > 0 && rdy) begin
            void'(mq.pop_front());
            model_pops++;
        end
        if (fifo_r_en) begin
            if (src_q.size() == 0) begin
                check("r_en_on_empty", {31'd0, fifo_r_en}, 32'd0);
                rd_pend = 1'b0;
            end else begin
                pend_word = src_q.pop_front();
                rd_pend   = 1'b1;
                mq.push_back('{rc: cyc, data: pend_word});
            end
        end else begin
            rd_pend = 1'b0;
        end
        prev_ren = fifo_r_en;
        cyc++;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((src_q.size() != 0 || mq.size() != 0) && n < budget) begin
            step(1'b1, 1'b1);
            n++;
        end
        check("drain_within_budget", {31'd0, (src_q.size() == 0 && mq.size() == 0)}, 32'd1);
    endtask

    task automatic clear_model();
        src_q.delete(); mq.delete();
        rd_pend = 1'b0; prev_ren = 1'b0; model_pops = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_ren, t_val, nren, first_v, last_v, vcnt;
        logic [31:0] vdata;

        // Reset state
        reset = 1'b0; enable = 1'b1; fifo_empty = 1'b1; m_ready = 1'b0; fifo_read_data = '0;
        #3;
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_buf_count", {30'd0, buf_count}, 32'd0);
        check("rst_r_en_empty", {31'd0, fifo_r_en}, 32'd0);
        fifo_empty = 1'b0; #1;
        check("rst_r_en_follows", {31'd0, fifo_r_en}, 32'd1);
        fifo_empty = 1'b1;
        #8 reset = 1'b1;

        // Single word
        src_q.push_back(32'hDEADBEEF);
        t_ren = -1; t_val = -1; nren = 0; vdata = '0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1);
            if (s_ren) begin nren++; if (t_ren < 0) t_ren = i; end
            if (s_valid && t_val < 0) begin t_val = i; vdata = s_data; end
        end
        check("single_ren_pulses", nren, 32'd1);
        check("single_latency", t_val - t_ren, 32'd2);
        check("single_data", vdata, 32'hDEADBEEF);
        check("single_bc_end", {30'd0, s_bc}, 32'd0);

        // Streaming 0..15
        got_q.delete();
        for (int i = 0; i < 16; i++) src_q.push_back(i);
        first_v = -1; last_v = -1; vcnt = 0;
        for (int i = 0; i < 40 && (src_q.size() != 0 || mq.size() != 0); i++) begin
            step(1'b1, 1'b1);
            if (s_valid) begin vcnt++; if (first_v < 0) first_v = i; last_v = i; end
        end
        check("stream_count", got_q.size(), 32'd16);
        for (int i = 0; i < 16 && i < got_q.size(); i++) check("stream_order", got_q[i], i);
        check("stream_valid_cycles", vcnt, 32'd16);
        check("stream_no_gaps", last_v - first_v, 32'd15);

        // Backpressure
        got_q.delete();
        for (int i = 0; i < 8; i++) src_q.push_back(32'h100 + i);
        nren = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            if (s_ren) nren++;
        end
        check("bp_reads", nren, 32'd3);
        check("bp_buf_count", {30'd0, s_bc}, 32'd3);
        check("bp_hold_data", s_data, 32'h100);
        step(1'b1, 1'b1);
        check("bp_resume", got_q.size(), 32'd1);
        run_until_idle(40);
        check("bp_count", got_q.size(), 32'd8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) check("bp_order", got_q[i], 32'h100 + i);

        // Enable gating
        got_q.delete();
        for (int i = 0; i < 6; i++) src_q.push_back(32'hA000 + i);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            if (s_ren) break;
        end
        nren = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1);
            if (s_ren) nren++;
        end
        check("en_no_reads", nren, 32'd0);
        check("en_delivered", got_q.size(), 32'd1);
        if (got_q.size() > 0) check("en_word", got_q[0], 32'hA000);
        run_until_idle(40);

        // Reset mid-stream with two buffered words and one in flight
        for (int i = 0; i < 5; i++) src_q.push_back(32'hB000 + i);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            if (s_bc == 2'd2) break;
        end
        check("mid_bc_before", {30'd0, s_bc}, 32'd2);
        #2; reset = 1'b0; fifo_empty = 1'b1; clear_model();
        #1;
        check("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("mid_rst_buf_count", {30'd0, buf_count}, 32'd0);
        check("mid_rst_r_en", {31'd0, fifo_r_en}, 32'd0);
        @(posedge clk); #2 reset = 1'b1;
        got_q.delete();
        src_q.push_back(32'hCAFEF00D);
        run_until_idle(20);
        check("post_rst_count", got_q.size(), 32'd1);
        if (got_q.size() > 0) check("post_rst_word", got_q[0], 32'hCAFEF00D);

`ifdef FIFO_READER_COUNT_EN
        // Counter wrap
        @(negedge clk); reset = 1'b0; fifo_empty = 1'b1; clear_model();
        @(posedge clk); #2 reset = 1'b1;
        for (int i = 0; i < 65535; i++) src_q.push_back(i);
        run_until_idle(70000);
        step(1'b1, 1'b0);
        check("cnt_ffff", {16'd0, words_delivered}, 32'h0000FFFF);
        src_q.push_back(32'h1);
        run_until_idle(20);
        step(1'b1, 1'b0);
        check("cnt_wrap0", {16'd0, words_delivered}, 32'h00000000);
        src_q.push_back(32'h2);
        run_until_idle(20);
        step(1'b1, 1'b0);
        check("cnt_one", {16'd0, words_delivered}, 32'h00000001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
